// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and constants for the forwarding / load-use hazard controller.
package fwd_hazard_unit_pkg;

  localparam int DEFAULT_REG_AW = 3;
  // Tag rd field is sized for the widest supported register file; narrower
  // register addresses are zero-extended into it.
  localparam int TAG_RD_W = 8;

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } stage_tag_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request and EX-stage mux-select response bundle for fwd_hazard_unit.
interface fwd_hazard_unit_if
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW = DEFAULT_REG_AW,
  parameter int CNT_W  = 16
);

  // No handshake: id_* describe the instruction in ID for the current cycle;
  // stall answers combinationally, fwd_sel_* answer one edge later (its EX cycle).
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic [1:0]        fwd_sel_a;
  logic [1:0]        fwd_sel_b;
  logic              stall;
  logic [CNT_W-1:0]  stall_count;
  stage_tag_t        dbg_ex;
  stage_tag_t        dbg_mem;
  stage_tag_t        dbg_wb;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_reg_write, id_mem_read, flush,
    input  fwd_sel_a, fwd_sel_b, stall, stall_count, dbg_ex, dbg_mem, dbg_wb
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_reg_write, id_mem_read, flush,
    output fwd_sel_a, fwd_sel_b, stall, stall_count, dbg_ex, dbg_mem, dbg_wb
  );

endinterface

// File: rtl/fwd_hazard_unit_pipe_tag_reg.sv
// One pipeline-stage destination tag; a bubble loads an all-zero (invalid) tag.
module pipe_tag_reg
  import fwd_hazard_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bubble_i,
  input  stage_tag_t d_i,
  output stage_tag_t q_o
);

  stage_tag_t tag_q;

  always_ff @(posedge clk) begin
    if (rst || bubble_i) begin
      tag_q <= '0;
    end else begin
      tag_q <= d_i;
    end
  end

  assign q_o = tag_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generation for the EX-stage operand muxes.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW   = DEFAULT_REG_AW,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  fwd_hazard_unit_if.slave hz
);

  stage_tag_t       id_tag;
  stage_tag_t       ex_q;
  stage_tag_t       mem_q;
  stage_tag_t       wb_q;
  logic             stall_w;
  logic             bubble;
  logic [1:0]       sel_a_q, sel_a_d;
  logic [1:0]       sel_b_q, sel_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic tag_match(stage_tag_t t, logic [REG_AW-1:0] src);
    logic src_ok;
    src_ok = !ZERO_REG || (src != '0);
    return t.valid && t.reg_write && (t.rd == TAG_RD_W'(src)) && src_ok;
  endfunction

  // EX holds the youngest producer, so it is checked first.
  function automatic logic [1:0] next_sel(logic [REG_AW-1:0] src);
    if (tag_match(ex_q, src))       return SEL_EXMEM;
    else if (tag_match(mem_q, src)) return SEL_MEMWB;
    else                            return SEL_RF;
  endfunction

  always_comb begin
    id_tag           = '0;
    id_tag.valid     = hz.id_valid;
    id_tag.rd        = TAG_RD_W'(hz.id_rd);
    id_tag.reg_write = hz.id_reg_write;
    id_tag.mem_read  = hz.id_mem_read;
  end

  assign stall_w = !hz.flush && hz.id_valid && ex_q.mem_read &&
                   (tag_match(ex_q, hz.id_rs) || tag_match(ex_q, hz.id_rt));
  assign bubble  = stall_w || hz.flush;

  always_comb begin
    sel_a_d = bubble ? SEL_RF : next_sel(hz.id_rs);
    sel_b_d = bubble ? SEL_RF : next_sel(hz.id_rt);
    cnt_d   = cnt_q;
    if (stall_w && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
      cnt_q   <= '0;
    end else begin
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      cnt_q   <= cnt_d;
    end
  end

  pipe_tag_reg u_ex  (.clk(clk), .rst(rst), .bubble_i(bubble), .d_i(id_tag), .q_o(ex_q));
  pipe_tag_reg u_mem (.clk(clk), .rst(rst), .bubble_i(1'b0),   .d_i(ex_q),   .q_o(mem_q));
  pipe_tag_reg u_wb  (.clk(clk), .rst(rst), .bubble_i(1'b0),   .d_i(mem_q),  .q_o(wb_q));

  assign hz.fwd_sel_a   = sel_a_q;
  assign hz.fwd_sel_b   = sel_b_q;
  assign hz.stall       = stall_w;
  assign hz.stall_count = cnt_q;
  assign hz.dbg_ex      = ex_q;
  assign hz.dbg_mem     = mem_q;
  assign hz.dbg_wb      = wb_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized and directed check of fwd_hazard_unit against an in-flight instruction model.
module tb_fwd_hazard_unit;
  import fwd_hazard_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.REG_AW(3), .CNT_W(16)) ifc ();
  fwd_hazard_unit_if #(.REG_AW(3), .CNT_W(2))  ifc2 ();

  fwd_hazard_unit #(.REG_AW(3), .ZERO_REG(1'b1), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .hz(ifc));
  fwd_hazard_unit #(.REG_AW(3), .ZERO_REG(1'b1), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .hz(ifc2));

  assign ifc2.id_valid     = ifc.id_valid;
  assign ifc2.id_rs        = ifc.id_rs;
  assign ifc2.id_rt        = ifc.id_rt;
  assign ifc2.id_rd        = ifc.id_rd;
  assign ifc2.id_reg_write = ifc.id_reg_write;
  assign ifc2.id_mem_read  = ifc.id_mem_read;
  assign ifc2.flush        = ifc.flush;

  // Model: instructions in flight, index 0 = EX (youngest), 1 = MEM, 2 = WB.
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit ld;
  } instr_t;

  instr_t live[3];
  int     n_stalls = 0;
  int     exp_a = 0;
  int     exp_b = 0;
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit produces(int age, int src);
    return live[age].v && live[age].rw && (live[age].rd == src) && (src != 0);
  endfunction

  function automatic int youngest(int src);
    for (int age = 0; age < 2; age++)
      if (produces(age, src)) return age + 1;
    return 0;
  endfunction

  function automatic int sat(int n, int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic cycle(input bit v, input int rs, input int rt, input int rd,
                       input bit rw, input bit ld, input bit fl, input bit r);
    bit exp_stall;
    @(negedge clk);
    rst              = r;
    ifc.id_valid     = v;
    ifc.id_rs        = 3'(rs);
    ifc.id_rt        = 3'(rt);
    ifc.id_rd        = 3'(rd);
    ifc.id_reg_write = rw;
    ifc.id_mem_read  = ld;
    ifc.flush        = fl;
    #1;
    exp_stall = !fl && v && live[0].ld && (produces(0, rs) || produces(0, rt));
    check_eq("stall",      32'(ifc.stall),       32'(exp_stall));
    check_eq("stall_c2",   32'(ifc2.stall),      32'(exp_stall));
    check_eq("sel_a",      32'(ifc.fwd_sel_a),   32'(exp_a));
    check_eq("sel_b",      32'(ifc.fwd_sel_b),   32'(exp_b));
    check_eq("ex_valid",   32'(ifc.dbg_ex.valid), 32'(live[0].v));
    check_eq("count",      32'(ifc.stall_count), 32'(sat(n_stalls, 65535)));
    check_eq("count_sat2", 32'(ifc2.stall_count), 32'(sat(n_stalls, 3)));
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 3; i++) live[i] = '{0, 0, 0, 0};
      n_stalls = 0;
      exp_a    = 0;
      exp_b    = 0;
    end else begin
      if (exp_stall || fl) begin
        exp_a = 0;
        exp_b = 0;
      end else begin
        exp_a = youngest(rs);
        exp_b = youngest(rt);
      end
      if (exp_stall) n_stalls++;
      live[2] = live[1];
      live[1] = live[0];
      if (exp_stall || fl) live[0] = '{0, 0, 0, 0};
      else                 live[0] = '{v, rd, rw, ld};
    end
  endtask

  task automatic nop();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) live[i] = '{0, 0, 0, 0};
    ifc.id_valid = 0; ifc.id_rs = 0; ifc.id_rt = 0; ifc.id_rd = 0;
    ifc.id_reg_write = 0; ifc.id_mem_read = 0; ifc.flush = 0;
    repeat (2) @(posedge clk);

    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    nop();
    // back-to-back ALU dependence
    cycle(1, 1, 2, 3, 1, 0, 0, 0);
    cycle(1, 3, 1, 4, 1, 0, 0, 0);
    nop();
    // distance-2, then both stages writing r5
    cycle(1, 1, 1, 5, 1, 0, 0, 0);
    cycle(1, 2, 2, 6, 1, 0, 0, 0);
    cycle(1, 1, 5, 7, 1, 0, 0, 0);
    cycle(1, 0, 0, 5, 1, 0, 0, 0);
    cycle(1, 0, 0, 5, 1, 0, 0, 0);
    cycle(1, 1, 5, 7, 1, 0, 0, 0);
    nop(); nop();
    // load-use, consumer re-presented after the stall
    cycle(1, 0, 0, 2, 1, 1, 0, 0);
    cycle(1, 2, 1, 3, 1, 0, 0, 0);
    cycle(1, 2, 1, 3, 1, 0, 0, 0);
    nop(); nop();
    // register zero
    cycle(1, 0, 0, 0, 1, 1, 0, 0);
    cycle(1, 0, 0, 4, 1, 0, 0, 0);
    nop(); nop();
    // flush overrides load-use
    cycle(1, 0, 0, 2, 1, 1, 0, 0);
    cycle(1, 2, 2, 3, 1, 0, 1, 0);
    nop(); nop();
    // reset mid-stall
    cycle(1, 0, 0, 1, 1, 1, 0, 0);
    cycle(1, 1, 0, 3, 1, 0, 0, 1);
    nop();
    // four consecutive load-use stalls
    for (int k = 0; k < 4; k++) begin
      cycle(1, 0, 0, 1, 1, 1, 0, 0);
      cycle(1, 1, 0, 3, 1, 0, 0, 0);
    end
    nop(); nop();

    for (int k = 0; k < 600; k++) begin
      cycle($urandom_range(0, 9) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
